// File: rtl/decoder_seq_pkg.sv
// ============================================================================
// Module   : decoder_seq_pkg
// Brief    : Shared MODE and state encodings for the sequencing decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_seq_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD    = 2'b00;
   localparam mode_t MODE_LOAD    = 2'b01;
   localparam mode_t MODE_STEP_UP = 2'b10;
   localparam mode_t MODE_STEP_DN = 2'b11;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/decoder_seq_onehot_dec.sv
// ============================================================================
// Module   : onehot_dec
// Brief    : Combinational SEL_W-to-2**SEL_W binary-to-one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_dec #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [(1<<SEL_W)-1:0] dec
);

   localparam int OUT_W = 1 << SEL_W;

   for (genvar i = 0; i < OUT_W; i++) begin : g_bit
      assign dec[i] = (sel == SEL_W'(i));
   end

endmodule

`default_nettype wire

// File: rtl/decoder_seq.sv
// ============================================================================
// Module   : decoder_seq
// Brief    : Registered one-hot decoder with load / walk-up / walk-down modes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_seq
   import decoder_seq_pkg::*;
#(
   parameter int SEL_W            = 3,
   parameter bit IDLE_STEP_DN_TOP = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  EN,
   input  logic                  CLR,
   input  logic [1:0]            MODE,
   input  logic [SEL_W-1:0]      SEL,
   output logic [(1<<SEL_W)-1:0] X,
   output logic [SEL_W-1:0]      IDX,
   output logic                  ACTIVE,
   output logic                  WRAP
);

   localparam int               OUT_W    = 1 << SEL_W;
   localparam logic [SEL_W-1:0] c_maxIdx = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] c_dnEntry = IDLE_STEP_DN_TOP ? c_maxIdx : '0;

   logic [0:0]       r_state;
   logic [SEL_W-1:0] r_idx;
   logic [OUT_W-1:0] r_x;
   logic             r_wrap;

   logic [0:0]       w_nextState;
   logic [SEL_W-1:0] w_nextIdx;
   logic             w_nextWrap;
   logic [OUT_W-1:0] w_dec;

   always_comb begin
      w_nextState = r_state;
      w_nextIdx   = r_idx;
      w_nextWrap  = 1'b0;
      if (CLR) begin
         w_nextState = ST_IDLE;
         w_nextIdx   = '0;
      end else begin
         case (MODE)
            MODE_LOAD: begin
               w_nextState = ST_ACTIVE;
               w_nextIdx   = SEL;
            end
            MODE_STEP_UP: begin
               w_nextState = ST_ACTIVE;
               if (r_state == ST_ACTIVE) begin
                  w_nextIdx  = r_idx + SEL_W'(1);
                  w_nextWrap = (r_idx == c_maxIdx);
               end else begin
                  w_nextIdx = '0;
               end
            end
            MODE_STEP_DN: begin
               w_nextState = ST_ACTIVE;
               if (r_state == ST_ACTIVE) begin
                  w_nextIdx  = r_idx - SEL_W'(1);
                  w_nextWrap = (r_idx == '0);
               end else begin
                  w_nextIdx = c_dnEntry;
               end
            end
            default: ;
         endcase
      end
   end

   // X is always decoded from the next index so it can never hold more than one bit.
   onehot_dec #(
      .SEL_W (SEL_W)
   ) u_dec (
      .sel (w_nextIdx),
      .dec (w_dec)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_x     <= '0;
         r_wrap  <= 1'b0;
      end else if (EN) begin
         r_state <= w_nextState;
         r_idx   <= w_nextIdx;
         r_x     <= (w_nextState == ST_ACTIVE) ? w_dec : '0;
         r_wrap  <= w_nextWrap;
      end else begin
         r_wrap  <= 1'b0;
      end
   end

   assign X      = r_x;
   assign IDX    = r_idx;
   assign ACTIVE = (r_state == ST_ACTIVE);
   assign WRAP   = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq.sv
// ============================================================================
// Module   : tb_decoder_seq
// Brief    : Directed vector table, corner sequences and reference-model run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_seq;

   localparam logic [1:0] HOLD = 2'b00;
   localparam logic [1:0] LOAD = 2'b01;
   localparam logic [1:0] UP   = 2'b10;
   localparam logic [1:0] DN   = 2'b11;

   logic       clk = 1'b0;
   logic       rstN;
   logic       en;
   logic       clr;
   logic [1:0] mode;
   logic [4:0] sel;

   logic [1:0]  x1;
   logic [0:0]  idx1;
   logic        act1, wrap1;
   logic [7:0]  x3;
   logic [2:0]  idx3;
   logic        act3, wrap3;
   logic [31:0] x5;
   logic [4:0]  idx5;
   logic        act5, wrap5;

   int nCmp = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   decoder_seq #(.SEL_W(1), .IDLE_STEP_DN_TOP(1'b0)) dut1 (
      .CLK(clk), .RST_N(rstN), .EN(en), .CLR(clr), .MODE(mode), .SEL(sel[0:0]),
      .X(x1), .IDX(idx1), .ACTIVE(act1), .WRAP(wrap1));

   decoder_seq #(.SEL_W(3), .IDLE_STEP_DN_TOP(1'b1)) dut3 (
      .CLK(clk), .RST_N(rstN), .EN(en), .CLR(clr), .MODE(mode), .SEL(sel[2:0]),
      .X(x3), .IDX(idx3), .ACTIVE(act3), .WRAP(wrap3));

   decoder_seq #(.SEL_W(5), .IDLE_STEP_DN_TOP(1'b1)) dut5 (
      .CLK(clk), .RST_N(rstN), .EN(en), .CLR(clr), .MODE(mode), .SEL(sel),
      .X(x5), .IDX(idx5), .ACTIVE(act5), .WRAP(wrap5));

   typedef struct {
      logic       en;
      logic       clr;
      logic [1:0] mode;
      logic [4:0] sel;
      logic [7:0] expX;
      logic [2:0] expIdx;
      logic       expAct;
      logic       expWrap;
   } vec_t;

   vec_t vecs[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [4:0] s);
      en = e; clr = c; mode = m; sel = s;
   endtask

   function automatic vec_t mk(input logic e, input logic c, input logic [1:0] m,
                               input logic [4:0] s, input logic [7:0] ex,
                               input logic [2:0] ei, input logic ea, input logic ew);
      vec_t v;
      v.en = e; v.clr = c; v.mode = m; v.sel = s;
      v.expX = ex; v.expIdx = ei; v.expAct = ea; v.expWrap = ew;
      return v;
   endfunction

   // Reference model state for the three instances (widths 1, 3, 5).
   int mSt[3], mIdx[3], mWrap[3];
   int mW[3]   = '{1, 3, 5};
   int mTop[3] = '{0, 1, 1};

   initial begin
      // SEL_W=3, IDLE_STEP_DN_TOP=1 instance; SEL is don't-care outside LOAD.
      vecs.push_back(mk(1, 0, LOAD, 5'd5,  8'h20, 3'd5, 1, 0));
      vecs.push_back(mk(1, 0, LOAD, 5'd0,  8'h01, 3'd0, 1, 0));
      vecs.push_back(mk(1, 0, LOAD, 5'd6,  8'h40, 3'd6, 1, 0));
      vecs.push_back(mk(1, 0, UP,   5'bx,  8'h80, 3'd7, 1, 0));
      vecs.push_back(mk(1, 0, UP,   5'bx,  8'h01, 3'd0, 1, 1));
      vecs.push_back(mk(1, 0, UP,   5'bx,  8'h02, 3'd1, 1, 0));
      vecs.push_back(mk(1, 1, LOAD, 5'd3,  8'h00, 3'd0, 0, 0));
      vecs.push_back(mk(1, 0, DN,   5'bx,  8'h80, 3'd7, 1, 0));
      vecs.push_back(mk(1, 0, DN,   5'bx,  8'h40, 3'd6, 1, 0));
      vecs.push_back(mk(1, 0, LOAD, 5'd2,  8'h04, 3'd2, 1, 0));
      vecs.push_back(mk(0, 0, UP,   5'bx,  8'h04, 3'd2, 1, 0));
      vecs.push_back(mk(0, 0, UP,   5'bx,  8'h04, 3'd2, 1, 0));
      vecs.push_back(mk(0, 0, UP,   5'bx,  8'h04, 3'd2, 1, 0));
      vecs.push_back(mk(1, 1, LOAD, 5'd3,  8'h00, 3'd0, 0, 0));
      vecs.push_back(mk(1, 0, UP,   5'bx,  8'h01, 3'd0, 1, 0));
      vecs.push_back(mk(1, 0, DN,   5'bx,  8'h80, 3'd7, 1, 1));
      vecs.push_back(mk(1, 0, HOLD, 5'bx,  8'h80, 3'd7, 1, 0));
      vecs.push_back(mk(1, 0, UP,   5'bx,  8'h01, 3'd0, 1, 1));
      vecs.push_back(mk(0, 0, DN,   5'bx,  8'h01, 3'd0, 1, 0));
      vecs.push_back(mk(1, 0, LOAD, 5'd7,  8'h80, 3'd7, 1, 0));

      rstN = 1'b0;
      drive(0, 0, HOLD, 5'd0);
      tick();
      tick();
      chk("reset X",      {24'd0, x3},   32'h0);
      chk("reset IDX",    {29'd0, idx3}, 32'h0);
      chk("reset ACTIVE", {31'd0, act3}, 32'h0);
      chk("reset WRAP",   {31'd0, wrap3}, 32'h0);
      rstN = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].sel);
         tick();
         chk($sformatf("vec%0d X", i),      {24'd0, x3},    {24'd0, vecs[i].expX});
         chk($sformatf("vec%0d IDX", i),    {29'd0, idx3},  {29'd0, vecs[i].expIdx});
         chk($sformatf("vec%0d ACTIVE", i), {31'd0, act3},  {31'd0, vecs[i].expAct});
         chk($sformatf("vec%0d WRAP", i),   {31'd0, wrap3}, {31'd0, vecs[i].expWrap});
      end

      // Asynchronous reset between clock edges.
      drive(1, 0, LOAD, 5'd5);
      tick();
      chk("pre-reset X", {24'd0, x3}, 32'h20);
      drive(0, 0, HOLD, 5'd0);
      #2;
      rstN = 1'b0;
      #1;
      chk("async reset X",      {24'd0, x3},    32'h0);
      chk("async reset IDX",    {29'd0, idx3},  32'h0);
      chk("async reset ACTIVE", {31'd0, act3},  32'h0);
      chk("async reset WRAP",   {31'd0, wrap3}, 32'h0);
      tick();
      rstN = 1'b1;

      // SEL_W=1 with IDLE_STEP_DN_TOP=0: entry at 0, then alternating wraps.
      drive(1, 0, DN, 5'd0);
      tick();
      chk("w1 dn-from-idle X",    {30'd0, x1},    32'h1);
      chk("w1 dn-from-idle WRAP", {31'd0, wrap1}, 32'h0);
      chk("w3 dn-from-idle X",    {24'd0, x3},    32'h80);
      drive(1, 0, UP, 5'd0);
      tick();
      chk("w1 up X",    {30'd0, x1},    32'h2);
      chk("w1 up WRAP", {31'd0, wrap1}, 32'h0);
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, (k % 2 == 0) ? UP : DN, 5'd0);
         tick();
         chk($sformatf("w1 alt%0d X", k),    {30'd0, x1},    (k % 2 == 0) ? 32'h1 : 32'h2);
         chk($sformatf("w1 alt%0d WRAP", k), {31'd0, wrap1}, 32'h1);
      end

      // Reference-model run across all three widths.
      rstN = 1'b0;
      drive(0, 0, HOLD, 5'd0);
      tick();
      rstN = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mSt[k] = 0; mIdx[k] = 0; mWrap[k] = 0;
      end
      for (int n = 0; n < 10000; n++) begin
         logic        e, c;
         logic [1:0]  m;
         logic [4:0]  s;
         e = ($urandom_range(0, 9) != 0);
         c = ($urandom_range(0, 24) == 0);
         m = 2'($urandom_range(0, 3));
         s = 5'($urandom);
         drive(e, c, m, (m == LOAD) ? s : 5'bx);
         for (int k = 0; k < 3; k++) begin
            int mx;
            mx = (1 << mW[k]) - 1;
            mWrap[k] = 0;
            if (e) begin
               if (c) begin
                  mSt[k] = 0; mIdx[k] = 0;
               end else if (m == LOAD) begin
                  mSt[k] = 1; mIdx[k] = int'(s) & mx;
               end else if (m == UP) begin
                  if (mSt[k] == 1) begin
                     mWrap[k] = (mIdx[k] == mx) ? 1 : 0;
                     mIdx[k]  = (mIdx[k] + 1) & mx;
                  end else begin
                     mSt[k] = 1; mIdx[k] = 0;
                  end
               end else if (m == DN) begin
                  if (mSt[k] == 1) begin
                     mWrap[k] = (mIdx[k] == 0) ? 1 : 0;
                     mIdx[k]  = (mIdx[k] - 1) & mx;
                  end else begin
                     mSt[k] = 1; mIdx[k] = (mTop[k] != 0) ? mx : 0;
                  end
               end
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            logic [31:0] ax, ai, ex;
            logic        aa, aw;
            case (k)
               0:       begin ax = {30'd0, x1}; ai = {31'd0, idx1}; aa = act1; aw = wrap1; end
               1:       begin ax = {24'd0, x3}; ai = {29'd0, idx3}; aa = act3; aw = wrap3; end
               default: begin ax = x5;          ai = {27'd0, idx5}; aa = act5; aw = wrap5; end
            endcase
            ex = (mSt[k] == 1) ? (32'd1 << mIdx[k]) : 32'd0;
            nCmp++;
            if (ax !== ex || ai !== 32'(mIdx[k]) || aa !== mSt[k][0] || aw !== mWrap[k][0]) begin
               nErr++;
               $display("FAIL model w%0d cyc%0d: got X=%0h IDX=%0d ACT=%0b WRAP=%0b, expected X=%0h IDX=%0d ACT=%0d WRAP=%0d",
                        mW[k], n, ax, ai, aa, aw, ex, mIdx[k], mSt[k], mWrap[k]);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule

`default_nettype wire
